// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer device: FSM states, register map, CTRL fields and MODE codes.
package timer_dev_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;

  localparam logic [1:0] ModeOneShot = 2'b00;
  localparam logic [1:0] ModeReload  = 2'b01;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a maskable interrupt.
// Auto-reload support is compiled in only when TIMER_DEV_RELOAD_EN is defined.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic        irqf_q, irqf_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;

  logic        ctrl_wr, preset_wr, reload;
  logic [1:0]  wr_mode;

  assign ctrl_wr   = we && (addr == AddrCtrl);
  assign preset_wr = we && (addr == AddrPreset);

`ifdef TIMER_DEV_RELOAD_EN
  assign wr_mode = din[CtrlModeMsb:CtrlModeLsb];
`else
  assign wr_mode = ModeOneShot;
`endif

  // Codes 10/11 fall back to one-shot.
  assign reload = (mode_q == ModeReload);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    en_d     = ctrl_wr ? din[CtrlEnBit] : en_q;
    mode_d   = ctrl_wr ? wr_mode : mode_q;
    im_d     = ctrl_wr ? din[CtrlImBit] : im_q;
    irqf_d   = ctrl_wr ? 1'b0 : irqf_q;
    preset_d = preset_wr ? din : preset_q;

    unique case (state_q)
      StIdle: begin
        if (en_q) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Setting the flag overrides a clear from a CTRL write on this same edge.
          count_d = 32'd0;
          irqf_d  = 1'b1;
          state_d = StInt;
        end
      end
      StInt: begin
        if (reload) begin
          irqf_d  = 1'b0;
          state_d = StLoad;
        end else begin
          en_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= ModeOneShot;
      im_q     <= 1'b0;
      irqf_q   <= 1'b0;
      preset_q <= PRESET_RST;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      irqf_q   <= irqf_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    dout = 32'd0;
    unique case (addr)
      AddrCtrl:   dout = {28'd0, im_q, mode_q, en_q};
      AddrPreset: dout = preset_q;
      AddrCount:  dout = count_q;
      default:    dout = 32'd0;
    endcase
  end

  assign irq = irqf_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: expected values are queued with stimulus and popped at sampling.
module tb_timer_dev;
  import timer_dev_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic        we    = 1'b0;
  logic [31:0] din   = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  timer_dev #(.PRESET_RST(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we  = 1'b0;
    din = 32'd0;
  endtask

  task automatic sb_rd(input logic [1:0] a);
    addr = a;
    #1;
    pop_check(dout);
  endtask

  task automatic sb_irq();
    pop_check({31'd0, irq});
  endtask

  initial begin
    // Reset values while reset is held low
    #2;
    push("rst_ctrl", 32'd0);   sb_rd(AddrCtrl);
    push("rst_preset", 32'd0); sb_rd(AddrPreset);
    push("rst_count", 32'd0);  sb_rd(AddrCount);
    push("rst_irq", 32'd0);    sb_irq();
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Register map: COUNT and reserved writes ignored
    wr_reg(AddrPreset, 32'd5);
    wr_reg(AddrCount, 32'h55);
    wr_reg(2'd3, 32'hAA);
    push("preset_rd", 32'd5);     sb_rd(AddrPreset);
    push("count_wr_ign", 32'd0);  sb_rd(AddrCount);
    push("rsvd_rd", 32'd0);       sb_rd(2'd3);

    // One-shot, P=5: irq rises 7 edges after the CTRL write and stays high
    wr_reg(AddrCtrl, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      tick();
      push($sformatf("os_irq_%0d", k), (k >= 7) ? 32'd1 : 32'd0);
      sb_irq();
      if (k == 2) begin push("os_cnt_load", 32'd5); sb_rd(AddrCount); end
      if (k == 6) begin push("os_cnt_one", 32'd1);  sb_rd(AddrCount); end
      if (k == 7) begin
        push("os_ctrl_int", 32'h9); sb_rd(AddrCtrl);
        push("os_cnt_zero", 32'd0); sb_rd(AddrCount);
      end
      if (k >= 8) begin push($sformatf("os_ctrl_%0d", k), 32'h8); sb_rd(AddrCtrl); end
    end

    // CTRL write clears the held flag
    wr_reg(AddrCtrl, 32'h0);
    push("clr_irq", 32'd0);   sb_irq();
    push("clr_count", 32'd0); sb_rd(AddrCount);
    tick();
    push("clr_irq2", 32'd0);  sb_irq();

    // Masked expiry, then unmasking via a write must not raise irq
    wr_reg(AddrPreset, 32'd10);
    wr_reg(AddrCtrl, 32'h1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      push($sformatf("mask_irq_%0d", k), 32'd0);
      sb_irq();
    end
    push("mask_ctrl_en_clr", 32'd0); sb_rd(AddrCtrl);
    wr_reg(AddrCtrl, 32'h8);
    for (int k = 1; k <= 3; k++) begin
      tick();
      push($sformatf("unmask_irq_%0d", k), 32'd0);
      sb_irq();
    end
    wr_reg(AddrCtrl, 32'h0);

    // CTRL write on the INT-entry edge: flag set wins, new IM exposes it
    wr_reg(AddrPreset, 32'd2);
    wr_reg(AddrCtrl, 32'h1);
    tick(); tick(); tick();
    wr_reg(AddrCtrl, 32'h9);
    push("race_irq", 32'd1);  sb_irq();
    push("race_ctrl", 32'h9); sb_rd(AddrCtrl);
    tick();
    push("race_ctrl_hw_clr", 32'h8); sb_rd(AddrCtrl);
    push("race_irq_held", 32'd1);    sb_irq();
    wr_reg(AddrCtrl, 32'h0);
    push("race_irq_clr", 32'd0); sb_irq();

    // Pause mid-count, resume reloads; PRESET write during CNT leaves COUNT alone
    wr_reg(AddrPreset, 32'd6);
    wr_reg(AddrCtrl, 32'h1);
    tick(); tick(); tick();
    push("pause_pre", 32'd5); sb_rd(AddrCount);
    wr_reg(AddrCtrl, 32'h0);
    tick(); tick(); tick();
    push("pause_hold", 32'd4); sb_rd(AddrCount);
    wr_reg(AddrCtrl, 32'h1);
    tick();
    push("resume_load_st", 32'd4); sb_rd(AddrCount);
    tick();
    push("resume_reload", 32'd6); sb_rd(AddrCount);
    wr_reg(AddrPreset, 32'd3);
    push("pre_wr_cnt", 32'd5);    sb_rd(AddrCount);
    push("pre_wr_preset", 32'd3); sb_rd(AddrPreset);
    tick(); tick(); tick(); tick();
    push("pre_wr_cnt_one", 32'd1); sb_rd(AddrCount);
    tick();
    push("pre_wr_cnt_end", 32'd0); sb_rd(AddrCount);
    push("pre_wr_irq_mask", 32'd0); sb_irq();
    wr_reg(AddrCtrl, 32'h0);

`ifdef TIMER_DEV_RELOAD_EN
    // Auto-reload, P=3: one-cycle pulse every 5 edges, EN stays set
    wr_reg(AddrPreset, 32'd3);
    wr_reg(AddrCtrl, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick();
      push($sformatf("ar_irq_%0d", k), (k % 5 == 0) ? 32'd1 : 32'd0);
      sb_irq();
    end
    push("ar_ctrl", 32'hB); sb_rd(AddrCtrl);
`else
    // Without reload support MODE is not stored and the timer stays one-shot
    wr_reg(AddrPreset, 32'd3);
    wr_reg(AddrCtrl, 32'hB);
    push("nr_ctrl", 32'h9); sb_rd(AddrCtrl);
    for (int k = 1; k <= 8; k++) begin
      tick();
      push($sformatf("nr_irq_%0d", k), (k >= 5) ? 32'd1 : 32'd0);
      sb_irq();
    end
    push("nr_ctrl_end", 32'h8); sb_rd(AddrCtrl);
`endif
    wr_reg(AddrCtrl, 32'h0);
    tick();

    // Asynchronous reset mid-count abandons the count
    wr_reg(AddrPreset, 32'd4);
    wr_reg(AddrCtrl, 32'h9);
    tick(); tick(); tick(); tick();
    push("prerst_cnt", 32'd2); sb_rd(AddrCount);
    #2;
    reset = 1'b0;
    push("arst_ctrl", 32'd0);   sb_rd(AddrCtrl);
    push("arst_preset", 32'd0); sb_rd(AddrPreset);
    push("arst_count", 32'd0);  sb_rd(AddrCount);
    push("arst_irq", 32'd0);    sb_irq();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      push($sformatf("postrst_irq_%0d", k), 32'd0);
      sb_irq();
    end
    push("postrst_count", 32'd0); sb_rd(AddrCount);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL expose parameter PRESET_RST, default 32'h0000_0000: reset value of the PRESET register.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  2  word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 SHALL have port we  input  1  register write enable from bridge.
REQ-006 SHALL have port din  input  32  write data.
REQ-007 SHALL have port dout  output  32  read data, combinational from addr.
REQ-008 SHALL have port irq  output  1  interrupt request, drives one HWInt line of the CP0.

Function
REQ-009 SHALL decode CTRL as: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 10/11 treated as 00), bit3 IM; all other bits read 0.
REQ-010 SHALL return dout = CTRL, PRESET, COUNT for addr 0/1/2; addr 3 reads 32'h0.
REQ-011 SHALL apply a write to CTRL or PRESET at the rising edge where we=1; writes to COUNT and addr 3 are ignored.
REQ-012 SHALL implement states IDLE, LOAD, CNT, INT.
REQ-013 IDLE: EN=1 -> LOAD next edge; otherwise stay, COUNT holds.
REQ-014 LOAD: COUNT <= PRESET; -> CNT.
REQ-015 CNT: EN=0 -> IDLE, COUNT holds; else COUNT>1 -> COUNT-1, stay; else COUNT <= 0, -> INT.
REQ-016 SHALL reach INT exactly P+2 edges after the edge writing EN=1 (P=PRESET>=1); P=0 behaves as P=1.
REQ-017 On entering INT SHALL set internal flag IRQF; irq = IRQF & IM.
REQ-018 INT, one-shot: hardware clears EN, -> IDLE; IRQF held until next CPU write to CTRL.
REQ-019 INT, auto-reload: EN kept, -> LOAD; IRQF cleared on the following edge (one-cycle pulse).
REQ-020 Simultaneous CTRL write and INT entry: IRQF set wins; CPU-written EN applies except in one-shot, where hardware clear wins.
REQ-021 PRESET write during CNT SHALL NOT alter COUNT; new value used at next LOAD.
REQ-022 IM=0 SHALL mask irq without clearing IRQF; setting IM later asserts irq if IRQF still set.

Reset
REQ-023 reset=0 SHALL immediately force: state IDLE, CTRL 0, PRESET PRESET_RST, COUNT 0, IRQF 0, irq 0.
REQ-024 Reset mid-count SHALL abandon the count; no irq after reset release until a new EN=1 write.

Configuration
REQ-025 SHALL use macro TIMER_DEV_RELOAD_EN: defined -> MODE bits stored and auto-reload supported; undefined -> MODE bits not stored, read 0, always one-shot.

Structure
REQ-026 SHALL place state encoding, addr constants (CTRL/PRESET/COUNT), CTRL bit indices and MODE codes in shared package timer_dev_pkg.
REQ-027 SHALL be a single module; no sub-module required.

Verification
REQ-028 Write PRESET=5, CTRL=32'h9 (EN, IM, one-shot) -> irq rises 7 edges after CTRL write, stays high; CTRL reads 32'h8.
REQ-029 Then write CTRL=32'h0 -> irq low next cycle, state IDLE, COUNT reads 0.
REQ-030 With macro: PRESET=3, CTRL=32'hB (auto-reload) -> irq one-cycle pulses every 5 cycles, EN stays 1.
REQ-031 PRESET=10, CTRL=32'h1 (IM=0) -> no irq; after expiry write CTRL=32'h8 -> irq stays low (write cleared IRQF).
REQ-032 Count running at COUNT=4, write CTRL=32'h0 -> COUNT holds 4; reassert EN -> reload from PRESET.
REQ-033 Assert reset with COUNT=2 -> all outputs 0 asynchronously, irq never asserts after release.
